router_fsm: RTL and testbench

- Control FSM for the 1x3 packet router; sits directly upstream of the three 16x9 output FIFOs and alongside the input register block.
- Decodes the 2-bit destination address in the header byte and sequences header, payload and parity loading.
- Stalls on a full destination FIFO and aborts on a destination soft reset.
- Produces the lfd_state strobe that each FIFO delays and stores as the header-marker bit.

---
 rtl/router_fsm.sv | 176 +++++++++++++++++
 tb/tb_router_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// router_fsm - control FSM for the 1x3 packet router.
//
// Decodes the destination address from the header byte. It then sequences
// the header, payload and parity loads into the selected output FIFO. It
// stalls while that FIFO is full and aborts when the destination FIFO is
// soft-reset.
//
// Optional feature (macro ROUTER_FSM_WAIT_TIMEOUT_EN): bounds the time spent
// in WAIT_TILL_EMPTY. After WAIT_TIMEOUT cycles with the destination FIFO
// still non-empty, the packet is dropped and a one-cycle pkt_drop pulse is
// raised. Without the macro the FSM waits indefinitely and pkt_drop is tied 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   pkt_valid      source is driving header/payload bytes
//   data_in[1:0]   header address bits
//   fifo_full      full flag of the selected FIFO
//   fifo_empty[2:0] per-FIFO empty flags
//   soft_rst[2:0]  per-FIFO soft-reset pulses
//   parity_done    parity byte captured by the input register block
//   low_pkt_valid  pkt_valid fell while stalled on full
//   dest_addr[1:0] latched destination address
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                  state decodes
//   write_enb_reg  FIFO write enable
//   busy           source must hold off
//   pkt_drop       one-cycle drop pulse (optional feature)
module router_fsm #(
  parameter logic [1:0]  ADDR_INVALID = 2'b11,
  parameter int unsigned WAIT_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_rst,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic [1:0] dest_addr,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       pkt_drop
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t state;
  state_t next_state;
  logic   header_hit;

  assign header_hit = (state == DECODE_ADDRESS) && pkt_valid &&
                      (data_in != ADDR_INVALID);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam logic [4:0] WAIT_LAST = 5'(WAIT_TIMEOUT - 1);

  logic [4:0] wait_cnt;
  logic       drop_now;
  logic       drop_q;
`else
  logic unused_wait_timeout;
  assign unused_wait_timeout = (WAIT_TIMEOUT != 0);
`endif

  // State and destination registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DECODE_ADDRESS;
      dest_addr <= '0;
    end else begin
      state <= next_state;
      if (header_hit) dest_addr <= data_in;
    end
  end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  // Held at zero outside WAIT_TILL_EMPTY, so it is zero on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= drop_now;
      if (state != WAIT_TILL_EMPTY) wait_cnt <= '0;
      else                          wait_cnt <= wait_cnt + 5'd1;
    end
  end

  assign pkt_drop = drop_q;
`else
  assign pkt_drop = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    next_state = state;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    drop_now   = 1'b0;
`endif
    case (state)
      DECODE_ADDRESS: begin
        if (header_hit)
          next_state = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty[dest_addr]) begin
          next_state = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = DECODE_ADDRESS;
          drop_now   = 1'b1;
`endif
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        // full takes precedence over the end of the packet
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: next_state = DECODE_ADDRESS;
    endcase

    // Soft reset of the selected FIFO overrides everything, including a drop
    if ((state != DECODE_ADDRESS) && soft_rst[dest_addr]) begin
      next_state = DECODE_ADDRESS;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
      drop_now   = 1'b0;
`endif
    end
  end

  // Moore output decode
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm - directed self-checking bench for router_fsm.
// Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
module tb_router_fsm;

  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0100;
  localparam logic [7:0] O_LAF  = 8'b0001_0101;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LP   = 8'b0000_0101;
  localparam logic [7:0] O_CPE  = 8'b0000_0011;
  localparam logic [7:0] O_WAIT = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_rst;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [1:0] dest_addr;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, pkt_drop;
  logic [7:0] outs;

  int total = 0;
  int bad   = 0;

  assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 write_enb_reg, rst_int_reg, busy};

  router_fsm #(.ADDR_INVALID(2'b11), .WAIT_TIMEOUT(30)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .dest_addr(dest_addr), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy),
    .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_rst = 3'b000; parity_done = 1'b0;
    low_pkt_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (outs !== O_DEC) begin
      bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_DEC);
    end
    total++;
    if (dest_addr !== 2'd0 || pkt_drop !== 1'b0) begin
      bad++; $display("FAIL reset_addr got=%0d drop=%b exp=0 drop=0", dest_addr, pkt_drop);
    end
    tick();
    total++;
    if (outs !== O_DEC) begin
      bad++; $display("FAIL reset_idle got=%b exp=%b", outs, O_DEC);
    end
  endtask

  task automatic test_packet();
    logic [7:0] exp [8] = '{O_LFD, O_LD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DEC};
    logic       pv  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int we_cnt = 0;
    int lfd_cnt = 0;
    data_in = 2'b01; fifo_empty = 3'b111;
    for (int i = 0; i < 8; i++) begin
      pkt_valid = pv[i];
      tick();
      if (i == 1) data_in = 2'b00;
      we_cnt += int'(write_enb_reg);
      lfd_cnt += int'(lfd_state);
      total++;
      if (outs !== exp[i]) begin
        bad++; $display("FAIL packet_step%0d got=%b exp=%b", i, outs, exp[i]);
      end
    end
    total++;
    if (dest_addr !== 2'd1) begin
      bad++; $display("FAIL packet_addr got=%0d exp=1", dest_addr);
    end
    total++;
    if (we_cnt != 5 || lfd_cnt != 1) begin
      bad++; $display("FAIL packet_counts we=%0d lfd=%0d exp we=5 lfd=1", we_cnt, lfd_cnt);
    end
  endtask

  task automatic test_invalid();
    pkt_valid = 1'b1; data_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs !== O_DEC || dest_addr !== 2'd1) begin
        bad++; $display("FAIL invalid_hdr%0d got=%b addr=%0d exp=%b addr=1", i, outs, dest_addr, O_DEC);
      end
    end
    pkt_valid = 1'b0;
  endtask

  // Leaves the FSM in LOAD_DATA for destination 2 with pkt_valid high
  task automatic test_wait();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b011;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (outs !== O_WAIT || dest_addr !== 2'd2) begin
        bad++; $display("FAIL wait_cycle%0d got=%b addr=%0d exp=%b addr=2", i, outs, dest_addr, O_WAIT);
      end
    end
    fifo_empty = 3'b111;
    tick();
    total++;
    if (outs !== O_LFD) begin
      bad++; $display("FAIL wait_exit got=%b exp=%b", outs, O_LFD);
    end
    tick();
    total++;
    if (outs !== O_LD) begin
      bad++; $display("FAIL wait_to_ld got=%b exp=%b", outs, O_LD);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp  [12] = '{O_FULL, O_FULL, O_FULL, O_LAF, O_LD, O_FULL, O_LAF,
                              O_LP, O_CPE, O_FULL, O_LAF, O_DEC};
    logic       full [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       lpv  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       pd   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // step 5: fifo_full and pkt_valid fall together in LOAD_DATA
    // step 9: full in CHECK_PARITY_ERROR; step 11: parity_done from LAF
    for (int i = 0; i < 12; i++) begin
      fifo_full = full[i]; low_pkt_valid = lpv[i]; parity_done = pd[i];
      if (i == 5) pkt_valid = 1'b0;
      tick();
      total++;
      if (outs !== exp[i]) begin
        bad++; $display("FAIL full_step%0d got=%b exp=%b", i, outs, exp[i]);
      end
    end
    fifo_full = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b0;
    total++;
    if (dest_addr !== 2'd2) begin
      bad++; $display("FAIL full_addr got=%0d exp=2", dest_addr);
    end
  endtask

  task automatic test_soft_rst();
    pkt_valid = 1'b1; data_in = 2'b00; fifo_empty = 3'b111;
    tick(); tick();
    total++;
    if (outs !== O_LD || dest_addr !== 2'd0) begin
      bad++; $display("FAIL srst_setup got=%b addr=%0d exp=%b addr=0", outs, dest_addr, O_LD);
    end
    soft_rst = 3'b010;
    tick();
    total++;
    if (outs !== O_LD) begin
      bad++; $display("FAIL srst_other got=%b exp=%b", outs, O_LD);
    end
    soft_rst = 3'b001; pkt_valid = 1'b0;
    tick();
    soft_rst = 3'b000;
    total++;
    if (outs !== O_DEC || dest_addr !== 2'd0) begin
      bad++; $display("FAIL srst_abort got=%b addr=%0d exp=%b addr=0", outs, dest_addr, O_DEC);
    end
  endtask

  task automatic test_mid_reset();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b111;
    tick(); tick();
    rst = 1'b1; pkt_valid = 1'b0;
    tick();
    rst = 1'b0;
    total++;
    if (outs !== O_DEC || dest_addr !== 2'd0) begin
      bad++; $display("FAIL mid_reset got=%b addr=%0d exp=%b addr=0", outs, dest_addr, O_DEC);
    end
  endtask

  task automatic test_wait_limit();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b011;
    tick();
    pkt_valid = 1'b0;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // 30 cycles in WAIT_TILL_EMPTY, then drop
    for (int i = 0; i < 29; i++) begin
      tick();
      total++;
      if (outs !== O_WAIT || pkt_drop !== 1'b0) begin
        bad++; $display("FAIL timeout_wait%0d got=%b drop=%b exp=%b drop=0", i, outs, pkt_drop, O_WAIT);
      end
    end
    tick();
    total++;
    if (outs !== O_DEC || pkt_drop !== 1'b1) begin
      bad++; $display("FAIL timeout_drop got=%b drop=%b exp=%b drop=1", outs, pkt_drop, O_DEC);
    end
    tick();
    total++;
    if (pkt_drop !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse got=%b exp=0", pkt_drop);
    end
`else
    for (int i = 0; i < 35; i++) begin
      tick();
      total++;
      if (outs !== O_WAIT || pkt_drop !== 1'b0) begin
        bad++; $display("FAIL nolimit_wait%0d got=%b drop=%b exp=%b drop=0", i, outs, pkt_drop, O_WAIT);
      end
    end
    soft_rst = 3'b100;
    tick();
    soft_rst = 3'b000;
    total++;
    if (outs !== O_DEC || pkt_drop !== 1'b0) begin
      bad++; $display("FAIL wait_srst got=%b drop=%b exp=%b drop=0", outs, pkt_drop, O_DEC);
    end
`endif
    fifo_empty = 3'b111;
  endtask

  initial begin
    test_reset();
    test_packet();
    test_invalid();
    test_wait();
    test_full();
    test_soft_rst();
    test_mid_reset();
    test_wait_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
